// File: rtl/bbs_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : bbs_seq_ctrl_if
// Description : Bus bundle between the Blum-Blum-Shub sequencer, the
//               Montgomery multiplier it drives and the random-word consumer.
//               "master" is the sequencer side, "slave" is the MMM/consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface bbs_seq_ctrl_if #(
    parameter int M = 8,
    parameter int W = 8
) ();
    // Montgomery multiplier request/response
    logic         mmm_start;
    logic [M-1:0] mmm_a;
    logic [M-1:0] mmm_b;
    logic [1:0]   mmm_done;
    logic [M-1:0] mmm_result;

    // Random word valid/ready stream
    logic [W-1:0] rand_word;
    logic         rand_valid;
    logic         rand_ready;

    modport master (
        output mmm_start, mmm_a, mmm_b,
        input  mmm_done, mmm_result,
        output rand_word, rand_valid,
        input  rand_ready
    );

    modport slave (
        input  mmm_start, mmm_a, mmm_b,
        output mmm_done, mmm_result,
        input  rand_word, rand_valid,
        output rand_ready
    );
endinterface
`default_nettype wire

// File: rtl/bbs_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bbs_seq_ctrl
// Description : Blum-Blum-Shub sequencer. Moves the seed into the Montgomery
//               domain, then repeatedly squares it through an external radix-2
//               Montgomery multiplier. Each new x is taken back to the normal
//               domain (multiply by 1) and its LSB is shifted into a W-bit word
//               delivered on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bbs_seq_ctrl #(
    parameter int M        = 8,   // operand/modulus width, R = 2^M
    parameter int W        = 8,   // output word width (>= 2)
    parameter int MAX_WAIT = 64   // cycles allowed from mmm_start to mmm_done
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          load,
    input  wire logic          enable,
    input  wire logic [M-1:0]  seed,
    input  wire logic [M-1:0]  n,
    input  wire logic [M-1:0]  r2_mod,
    bbs_seq_ctrl_if.master     bus,
    output logic               busy,
    output logic               err_seed,
    output logic               err_timeout
);

    localparam int c_CW = (W > 1) ? $clog2(W) : 1;
    localparam int c_WW = $clog2(MAX_WAIT + 1);

    localparam logic [c_CW-1:0] c_BIT_LAST  = c_CW'(W - 1);
    localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(MAX_WAIT - 1);
    localparam logic [M-1:0]    c_ONE       = M'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TOM_GO = 3'd1,
        S_TOM_WT = 3'd2,
        S_SQ_GO  = 3'd3,
        S_SQ_WT  = 3'd4,
        S_FRM_GO = 3'd5,
        S_FRM_WT = 3'd6,
        S_EMIT   = 3'd7
    } state_t;

    state_t          r_state;
    logic [M-1:0]    r_seed;
    logic [M-1:0]    r_n;
    logic [M-1:0]    r_r2;
    logic [M-1:0]    r_xm;        // current x in Montgomery form, always < N
    logic            r_bit;       // LSB of the latest normal-domain x
    logic [c_CW-1:0] r_bitcnt;
    logic [c_WW-1:0] r_wait;
    logic            r_start;
    logic [M-1:0]    r_a;
    logic [M-1:0]    r_b;
    logic [W-1:0]    r_word;
    logic            r_valid;
    logic            r_err_seed;
    logic            r_err_to;

    logic            w_done;
    logic            w_seed_bad;
    logic [M:0]      w_diff;
    logic [M-1:0]    w_red;

    // Product is only trusted on the full 2'b11 code
    assign w_done     = (bus.mmm_done == 2'b11);
    assign w_seed_bad = (seed == '0) || (seed >= n);

    // MMM output lies in [0,2N); one conditional subtract brings it into [0,N).
    // The extra top bit of the difference is the borrow, i.e. result < N.
    assign w_diff = {1'b0, bus.mmm_result} - {1'b0, r_n};
    assign w_red  = w_diff[M] ? bus.mmm_result : w_diff[M-1:0];

    assign bus.mmm_start  = r_start;
    assign bus.mmm_a      = r_a;
    assign bus.mmm_b      = r_b;
    assign bus.rand_word  = r_word;
    assign bus.rand_valid = r_valid;
    assign busy           = (r_state != S_IDLE);
    assign err_seed       = r_err_seed;
    assign err_timeout    = r_err_to;

    // Sequencer state machine with all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_seed     <= '0;
            r_n        <= '0;
            r_r2       <= '0;
            r_xm       <= '0;
            r_bit      <= 1'b0;
            r_bitcnt   <= '0;
            r_wait     <= '0;
            r_start    <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_word     <= '0;
            r_valid    <= 1'b0;
            r_err_seed <= 1'b0;
            r_err_to   <= 1'b0;
        end else begin
            // Start is a single-cycle pulse issued only from the *_GO states
            r_start <= 1'b0;

            // Word leaves on the handshake; valid only rises in EMIT, which
            // cannot coincide with a pending valid (SQ_GO stalls on it)
            if (r_valid && bus.rand_ready) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_seed     <= seed;
                        r_n        <= n;
                        r_r2       <= r2_mod;
                        r_err_seed <= w_seed_bad;
                        r_err_to   <= 1'b0;
                        if (!w_seed_bad) begin
                            r_word   <= '0;
                            r_bitcnt <= '0;
                            r_valid  <= 1'b0;
                            r_state  <= S_TOM_GO;
                        end
                    end
                end

                // seed * R^2 * R^-1 = seed * R (Montgomery form)
                S_TOM_GO: begin
                    r_a     <= r_seed;
                    r_b     <= r_r2;
                    r_start <= 1'b1;
                    r_wait  <= '0;
                    r_state <= S_TOM_WT;
                end

                // No prefetch: hold here while a word is unaccepted or paused
                S_SQ_GO: begin
                    if (!r_valid && enable) begin
                        r_a     <= r_xm;
                        r_b     <= r_xm;
                        r_start <= 1'b1;
                        r_wait  <= '0;
                        r_state <= S_SQ_WT;
                    end
                end

                // Multiplying by plain 1 strips the R factor
                S_FRM_GO: begin
                    r_a     <= r_xm;
                    r_b     <= c_ONE;
                    r_start <= 1'b1;
                    r_wait  <= '0;
                    r_state <= S_FRM_WT;
                end

                S_TOM_WT, S_SQ_WT, S_FRM_WT: begin
                    if (w_done) begin
                        case (r_state)
                            S_TOM_WT: begin
                                r_xm    <= w_red;
                                r_state <= S_SQ_GO;
                            end
                            S_SQ_WT: begin
                                r_xm    <= w_red;
                                r_state <= S_FRM_GO;
                            end
                            default: begin
                                r_bit   <= w_red[0];
                                r_state <= S_EMIT;
                            end
                        endcase
                    end else if (r_wait == c_WAIT_LAST) begin
                        // MMM is presumed dead: drop everything in progress
                        r_err_to <= 1'b1;
                        r_valid  <= 1'b0;
                        r_word   <= '0;
                        r_bitcnt <= '0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_wait <= r_wait + c_WW'(1);
                    end
                end

                // First generated bit ends up in the MSB of the word
                S_EMIT: begin
                    r_word <= {r_word[W-2:0], r_bit};
                    if (r_bitcnt == c_BIT_LAST) begin
                        r_valid  <= 1'b1;
                        r_bitcnt <= '0;
                    end else begin
                        r_bitcnt <= r_bitcnt + c_CW'(1);
                    end
                    r_state <= S_SQ_GO;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bbs_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bbs_seq_ctrl
// Description : Self-checking bench for bbs_seq_ctrl with a behavioural
//               radix-2 Montgomery multiplier and a word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bbs_seq_ctrl;

    localparam int M        = 8;
    localparam int W        = 8;
    localparam int MAX_WAIT = 64;
    localparam int LAT      = 3;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic         load   = 1'b0;
    logic         enable = 1'b0;
    logic [M-1:0] seed   = '0;
    logic [M-1:0] n      = '0;
    logic [M-1:0] r2_mod = '0;
    logic         busy;
    logic         err_seed;
    logic         err_timeout;

    bbs_seq_ctrl_if #(.M(M), .W(W)) bus ();

    bbs_seq_ctrl #(.M(M), .W(W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .enable      (enable),
        .seed        (seed),
        .n           (n),
        .r2_mod      (r2_mod),
        .bus         (bus),
        .busy        (busy),
        .err_seed    (err_seed),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_pops   = 0;
    int           n_starts = 0;
    int           mmm_mode = 0;   // 0 normal, 1 never done, 2 result + N
    logic [W-1:0] sb_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Radix-2 Montgomery product, output in [0,2N)
    function automatic logic [M-1:0] mont(input logic [M-1:0] a, input logic [M-1:0] b,
                                          input logic [M-1:0] nn);
        logic [M+1:0] t;
        t = '0;
        for (int i = 0; i < M; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, nn};
            t = t >> 1;
        end
        return t[M-1:0];
    endfunction

    // Expected words from plain modular squaring in the normal domain
    task automatic push_words(input int s, input int nn, input int nw);
        int x;
        logic [W-1:0] word;
        x = s;
        for (int w = 0; w < nw; w++) begin
            word = '0;
            for (int b = 0; b < W; b++) begin
                x = (x * x) % nn;
                word = {word[W-2:0], 1'(x & 1)};
            end
            sb_q.push_back(word);
        end
    endtask

    // Behavioural MMM: answers LAT cycles after start, with noise on done otherwise
    initial begin
        logic [M-1:0] op_a;
        logic [M-1:0] op_b;
        logic [M-1:0] r;
        int cnt;
        cnt = 0;
        op_a = '0;
        op_b = '0;
        bus.mmm_done   = 2'b00;
        bus.mmm_result = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                cnt = 0;
                bus.mmm_done = 2'b00;
            end else if (bus.mmm_start) begin
                op_a = bus.mmm_a;
                op_b = bus.mmm_b;
                cnt  = LAT;
                bus.mmm_done   = 2'($urandom_range(0, 2));
                bus.mmm_result = M'($urandom);
            end else if (cnt > 0 && !(cnt == 1 && mmm_mode != 1)) begin
                cnt--;
                bus.mmm_done   = 2'($urandom_range(0, 2));
                bus.mmm_result = M'($urandom);
            end else if (cnt == 1) begin
                cnt = 0;
                chk("op_a_stable", bus.mmm_a, op_a);
                chk("op_b_stable", bus.mmm_b, op_b);
                r = mont(op_a, op_b, n);
                if (mmm_mode == 2) begin
                    if (r >= n) r = r - n;
                    r = r + n;
                end
                bus.mmm_result = r;
                bus.mmm_done   = 2'b11;
            end else begin
                // Idle: occasionally a spurious full-valid code with garbage
                if (mmm_mode != 1 && $urandom_range(0, 3) == 0) bus.mmm_done = 2'b11;
                else bus.mmm_done = 2'($urandom_range(0, 2));
                bus.mmm_result = M'($urandom);
            end
        end
    end

    // Output monitor and scoreboard
    initial begin
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mmm_start) begin
                chk("start_gap", prev_start, 1'b0);
                n_starts++;
            end
            prev_start = bus.mmm_start;
            if (!rst && bus.rand_valid && bus.rand_ready) begin
                chk("sb_nonempty", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) chk("rand_word", bus.rand_word, sb_q.pop_front());
                n_pops++;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [M-1:0] s, input logic [M-1:0] nn, input logic [M-1:0] r2);
        @(posedge clk);
        #1;
        seed   = s;
        n      = nn;
        r2_mod = r2;
        load   = 1'b1;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic wait_pops(input string tag, input int target, input int limit);
        int k;
        k = 0;
        while (n_pops < target && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(tag, n_pops >= target, 1'b1);
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int k;
        k = 0;
        while (!bus.rand_valid && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(tag, bus.rand_valid, 1'b1);
    endtask

    task automatic wait_start(input string tag, input int limit);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.mmm_start && k < limit) begin
            @(negedge clk);
            k++;
        end
        chk(tag, bus.mmm_start, 1'b1);
    endtask

    task automatic chk_zero(input string pfx);
        chk({pfx, "_busy"},   busy,           0);
        chk({pfx, "_start"},  bus.mmm_start,  0);
        chk({pfx, "_a"},      bus.mmm_a,      0);
        chk({pfx, "_b"},      bus.mmm_b,      0);
        chk({pfx, "_word"},   bus.rand_word,  0);
        chk({pfx, "_valid"},  bus.rand_valid, 0);
        chk({pfx, "_errs"},   err_seed,       0);
        chk({pfx, "_errt"},   err_timeout,    0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int base;
        int k;
        logic held;
        bus.rand_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk_zero("rst");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Test 1: basic run, two words, valid lasts one cycle
        enable = 1'b1;
        bus.rand_ready = 1'b1;
        base = n_pops;
        push_words(3, 77, 4);
        do_load(8'd3, 8'd77, 8'd9);
        chk("t1_busy", busy, 1'b1);
        wait_valid("t1_valid_seen", 400);
        @(negedge clk);
        chk("t1_valid_1cyc", bus.rand_valid, 1'b0);
        wait_pops("t1_two_words", base + 2, 400);

        // Test 2: backpressure holds word and stops generation
        do_reset();
        bus.rand_ready = 1'b0;
        base = n_pops;
        push_words(3, 77, 4);
        do_load(8'd3, 8'd77, 8'd9);
        wait_valid("t2_valid_seen", 400);
        s0 = n_starts;
        held = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (bus.rand_word != 8'h99 || !bus.rand_valid) held = 1'b0;
        end
        chk("t2_word_held", held, 1'b1);
        chk("t2_word_val", bus.rand_word, 8'h99);
        chk("t2_no_start", n_starts - s0, 0);
        @(posedge clk);
        #1;
        bus.rand_ready = 1'b1;
        wait_pops("t2_resume", base + 2, 400);

        // Test 3: invalid seeds rejected, valid load clears the flag
        do_reset();
        s0 = n_starts;
        do_load(8'd0, 8'd77, 8'd9);
        @(negedge clk);
        chk("t3_err_zero", err_seed, 1'b1);
        chk("t3_busy_zero", busy, 1'b0);
        do_load(8'd77, 8'd77, 8'd9);
        repeat (3) @(negedge clk);
        chk("t3_err_eqn", err_seed, 1'b1);
        chk("t3_busy_eqn", busy, 1'b0);
        chk("t3_no_start", n_starts - s0, 0);
        push_words(3, 77, 4);
        do_load(8'd3, 8'd77, 8'd9);
        @(negedge clk);
        chk("t3_err_clr", err_seed, 1'b0);
        chk("t3_busy_ok", busy, 1'b1);

        // Test 4: MMM never answers
        do_reset();
        mmm_mode = 1;
        do_load(8'd3, 8'd77, 8'd9);
        wait_start("t4_start", 20);
        k = 0;
        while (!err_timeout && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("t4_timeout_cycles", k, MAX_WAIT);
        chk("t4_busy", busy, 1'b0);
        chk("t4_valid", bus.rand_valid, 1'b0);
        mmm_mode = 0;
        push_words(3, 77, 4);
        do_load(8'd3, 8'd77, 8'd9);
        @(negedge clk);
        chk("t4_errt_clr", err_timeout, 1'b0);

        // Test 5: unreduced results give the same words
        do_reset();
        mmm_mode = 2;
        base = n_pops;
        push_words(3, 77, 4);
        do_load(8'd3, 8'd77, 8'd9);
        wait_pops("t5_two_words", base + 2, 400);
        mmm_mode = 0;

        // Other moduli/seeds, incl. seed = N-1, and an enable pause
        do_reset();
        base = n_pops;
        push_words(76, 77, 4);
        do_load(8'd76, 8'd77, 8'd9);
        wait_pops("t5b_seed_max", base + 1, 400);
        do_reset();
        base = n_pops;
        push_words(7, 33, 4);
        do_load(8'd7, 8'd33, 8'd31);
        repeat (30) @(negedge clk);
        enable = 1'b0;
        repeat (30) @(negedge clk);
        s0 = n_starts;
        repeat (40) @(negedge clk);
        chk("t5c_paused", n_starts - s0, 0);
        chk("t5c_busy", busy, 1'b1);
        enable = 1'b1;
        wait_pops("t5c_resume", base + 2, 600);

        // Test 6: load while busy ignored, reset mid-square
        do_reset();
        base = n_pops;
        push_words(3, 77, 4);
        do_load(8'd3, 8'd77, 8'd9);
        wait_start("t6_tom_start", 20);
        do_load(8'd0, 8'd77, 8'd9);
        @(negedge clk);
        chk("t6_busy_load_err", err_seed, 1'b0);
        chk("t6_busy_load_busy", busy, 1'b1);
        wait_pops("t6_word", base + 1, 400);
        wait_start("t6_sq_start", 40);
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk_zero("t6_rst");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        s0 = n_starts;
        repeat (10) @(negedge clk);
        chk("t6_idle_busy", busy, 1'b0);
        chk("t6_idle_start", n_starts - s0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
